pc_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the PC register. Each cycle it computes pc_next (the PC register's pc_new input)
//  and decides whether the PC holds, steps or redirects.
//  It runs the instruction-memory req/ack handshake and holds the fetched instruction in a 1-entry output buffer.
//  It flushes on branch or trap redirects.

---
 rtl/pc_fetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch sequencer that sits beside the PC register.
// Each cycle it computes pc_next_o for the PC register and decides whether the PC
// holds, steps by PC_STEP or is redirected. It also runs the instruction-memory
// req/ack handshake and keeps the fetched word in a one-entry output buffer.
// A redirect flushes that buffer.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), asynchronous active-low reset
//   pc_cur_i / pc_next_o       PC register output / PC register pc_new input
//   imem_req_o, imem_addr_o    fetch request and address (address held while req is high)
//   imem_ack_i, imem_rdata_i   fetch complete, with read data valid in the same cycle
//   inst_valid_o, inst_o,      output buffer: valid flag, instruction word and its address
//   inst_pc_o
//   stall_i                    downstream not ready; the buffer is consumed when valid && !stall
//   br_taken_i, br_target_i    branch redirect
//   trap_req_i, trap_vec_i     trap redirect; these exist only when PC_CTRL_TRAP_EN is defined
//
// Configuration macro: PC_CTRL_TRAP_EN adds the trap redirect. A trap has priority over a branch.
//
// state | meaning
// IDLE  | first cycle after reset, no fetch
// ISSUE | may issue a fetch at pc_cur (a zero-wait ack stays here)
// WAIT  | fetch outstanding, result will be kept
// DRAIN | fetch outstanding after a redirect, result will be dropped
module pc_fetch_ctrl #(
  parameter int unsigned PC_STEP    = 4,
  parameter int unsigned ALIGN_BITS = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_cur_i,
  output logic [31:0] pc_next_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i
`ifdef PC_CTRL_TRAP_EN
  ,
  input  logic        trap_req_i,
  input  logic [31:0] trap_vec_i
`endif
);

  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << ALIGN_BITS) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic        redir;
  logic [31:0] redir_tgt;
  logic        can_issue;

`ifdef PC_CTRL_TRAP_EN
  assign redir     = trap_req_i | br_taken_i;
  assign redir_tgt = (trap_req_i ? trap_vec_i : br_target_i) & ALIGN_MASK;
`else
  assign redir     = br_taken_i;
  assign redir_tgt = br_target_i & ALIGN_MASK;
`endif

  // Only issue when the buffer is empty or being consumed this cycle.
  // That way every ack finds room in the buffer.
  assign can_issue = (!inst_valid_q || !stall_i) && !redir;

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    pc_next_o    = pc_cur_i;
    imem_req_o   = 1'b0;
    imem_addr_o  = req_addr_q;

    if (inst_valid_q && !stall_i) begin
      inst_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (redir) begin
          pc_next_o    = redir_tgt;
          inst_valid_d = 1'b0;
          inst_d       = NOP_INST;
        end else if (can_issue) begin
          imem_req_o  = 1'b1;
          imem_addr_o = pc_cur_i;
          req_addr_d  = pc_cur_i;
          pc_next_o   = pc_cur_i + PC_STEP;
          if (imem_ack_i) begin
            inst_valid_d = 1'b1;
            inst_d       = imem_rdata_i;
            inst_pc_d    = pc_cur_i;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        imem_req_o = 1'b1;
        if (redir) begin
          // The outstanding fetch is now stale. If it completes this cycle it is dropped here.
          // Otherwise DRAIN waits for it and drops it.
          pc_next_o    = redir_tgt;
          inst_valid_d = 1'b0;
          inst_d       = NOP_INST;
          state_d      = imem_ack_i ? S_ISSUE : S_DRAIN;
        end else if (imem_ack_i) begin
          inst_valid_d = 1'b1;
          inst_d       = imem_rdata_i;
          inst_pc_d    = req_addr_q;
          state_d      = S_ISSUE;
        end
      end
      S_DRAIN: begin
        // The buffer is already flushed, so a further redirect only moves the PC.
        imem_req_o = 1'b1;
        if (redir) begin
          pc_next_o = redir_tgt;
        end
        if (imem_ack_i) begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      req_addr_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_cur, pc_next, imem_addr, imem_rdata, inst, inst_pc, br_target;
  logic        imem_req, imem_ack, inst_valid, stall, br_taken;
`ifdef PC_CTRL_TRAP_EN
  logic        trap_req;
  logic [31:0] trap_vec;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0000 ^ {a[7:0], 24'h0};
  endfunction

  // Memory returns a word derived from the requested address.
  assign imem_rdata = memf(imem_addr);

  // PC register model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_cur <= '0;
    else        pc_cur <= pc_next;
  end

  pc_fetch_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .pc_cur_i    (pc_cur),
    .pc_next_o   (pc_next),
    .imem_req_o  (imem_req),
    .imem_addr_o (imem_addr),
    .imem_ack_i  (imem_ack),
    .imem_rdata_i(imem_rdata),
    .inst_valid_o(inst_valid),
    .inst_o      (inst),
    .inst_pc_o   (inst_pc),
    .stall_i     (stall),
    .br_taken_i  (br_taken),
    .br_target_i (br_target)
`ifdef PC_CTRL_TRAP_EN
    ,
    .trap_req_i  (trap_req),
    .trap_vec_i  (trap_vec)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.pc   = a;
    e.data = memf(a);
    sb_q.push_back(e);
  endtask

  // When the buffer is consumed, it must hold the oldest expected fetch.
  task automatic sb_check();
    exp_t e;
    if (inst_valid === 1'b1 && stall === 1'b0) begin
      chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_inst", inst, e.data);
        chk("sb_inst_pc", inst_pc, e.pc);
      end
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    sb_check();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] tgt;
    rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
`ifdef PC_CTRL_TRAP_EN
    trap_req = 1'b0; trap_vec = '0;
`endif
    #12;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    chk("idle_pcn", pc_next, 32'h0);
    to_pos();

    // 1: zero-wait memory
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      chk("t1_valid", 32'(inst_valid), 32'(i > 0));
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr", imem_addr, 32'(4 * i));
      chk("t1_pcn", pc_next, 32'(4 * i + 4));
      push_exp(32'(4 * i));
      to_pos();
    end

    // 2: three-cycle ack latency at 0x10
    imem_ack = 1'b0;
    to_neg();
    chk("t2_req0", 32'(imem_req), 32'd1);
    chk("t2_addr0", imem_addr, 32'h10);
    chk("t2_pcn0", pc_next, 32'h14);
    to_pos();
    to_neg();
    chk("t2_req1", 32'(imem_req), 32'd1);
    chk("t2_addr1", imem_addr, 32'h10);
    chk("t2_pcn1", pc_next, 32'h14);
    chk("t2_valid1", 32'(inst_valid), 32'd0);
    to_pos();
    imem_ack = 1'b1;
    to_neg();
    chk("t2_req2", 32'(imem_req), 32'd1);
    chk("t2_addr2", imem_addr, 32'h10);
    push_exp(32'h10);
    to_pos();
    for (int a = 'h14; a <= 'h20; a += 4) begin
      to_neg();
      if (a == 'h14) begin
        chk("t2_pc_cur", pc_cur, 32'h14);
        chk("t2_valid", 32'(inst_valid), 32'd1);
      end
      chk("t2_addr", imem_addr, 32'(a));
      push_exp(32'(a));
      to_pos();
    end

    // 3: stall holds the buffered word at 0x20
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      chk("t3_valid", 32'(inst_valid), 32'd1);
      chk("t3_inst_pc", inst_pc, 32'h20);
      chk("t3_inst", inst, memf(32'h20));
      chk("t3_req", 32'(imem_req), 32'd0);
      chk("t3_pcn", pc_next, 32'h24);
      to_pos();
    end
    stall = 1'b0;
    to_neg();
    chk("t3_rel_req", 32'(imem_req), 32'd1);
    chk("t3_rel_addr", imem_addr, 32'h24);
    chk("t3_rel_pcn", pc_next, 32'h28);
    push_exp(32'h24);
    to_pos();

    // 4: branch during WAIT, then drain
    imem_ack = 1'b0;
    to_neg();
    chk("t4_addr", imem_addr, 32'h28);
    to_pos();
    br_taken = 1'b1; br_target = 32'h103;
    to_neg();
    chk("t4_wait_req", 32'(imem_req), 32'd1);
    chk("t4_wait_addr", imem_addr, 32'h28);
    chk("t4_pcn", pc_next, 32'h100);
    to_pos();
    br_taken = 1'b0; imem_ack = 1'b1;
    to_neg();
    chk("t4_drain_req", 32'(imem_req), 32'd1);
    chk("t4_drain_addr", imem_addr, 32'h28);
    chk("t4_drain_pcn", pc_next, 32'h100);
    chk("t4_flush_valid", 32'(inst_valid), 32'd0);
    chk("t4_flush_inst", inst, NOP);
    to_pos();
    to_neg();
    chk("t4_discard_valid", 32'(inst_valid), 32'd0);
    chk("t4_new_addr", imem_addr, 32'h100);
    chk("t4_new_pcn", pc_next, 32'h104);
    push_exp(32'h100);
    to_pos();

    // 5: wrap at the top of the address space, then reset mid-WAIT
    br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
    to_neg();
    chk("t5_redir_req", 32'(imem_req), 32'd0);
    chk("t5_redir_pcn", pc_next, 32'hFFFF_FFFC);
    to_pos();
    br_taken = 1'b0;
    to_neg();
    chk("t5_flush_valid", 32'(inst_valid), 32'd0);
    chk("t5_pc_cur", pc_cur, 32'hFFFF_FFFC);
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    chk("t5_wrap_pcn", pc_next, 32'h0);
    push_exp(32'hFFFF_FFFC);
    to_pos();
    imem_ack = 1'b0;
    to_neg();
    chk("t5_addr0", imem_addr, 32'h0);
    chk("t5_pcn4", pc_next, 32'h4);
    to_pos();
    to_neg();
    chk("t5_wait_req", 32'(imem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_req", 32'(imem_req), 32'd0);
    chk("t5_rst_valid", 32'(inst_valid), 32'd0);
    chk("t5_rst_inst", inst, NOP);
    chk("t5_rst_inst_pc", inst_pc, 32'h0);
    chk("t5_rst_pcn", pc_next, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    to_pos();

    // 6: redirect priority (trap beats branch when the trap feature is present)
    imem_ack = 1'b1;
    br_taken = 1'b1; br_target = 32'h80;
`ifdef PC_CTRL_TRAP_EN
    trap_req = 1'b1; trap_vec = 32'h200;
    tgt = 32'h200;
`else
    tgt = 32'h80;
`endif
    to_neg();
    chk("t6_pcn", pc_next, tgt);
    chk("t6_req", 32'(imem_req), 32'd0);
    to_pos();
    br_taken = 1'b0;
`ifdef PC_CTRL_TRAP_EN
    trap_req = 1'b0;
`endif
    to_neg();
    chk("t6_addr", imem_addr, tgt);
    push_exp(tgt);
    to_pos();
    imem_ack = 1'b0;
    to_neg();
    chk("t6_valid", 32'(inst_valid), 32'd1);
    to_pos();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
